// File: rtl/point_jacobian.sv
// Affine (x,y) + random z -> Jacobian (x*z^2, y*z^3, z) mod p via one bit-serial Montgomery multiplier run 5x.
// Latency 5*(LEN+1)+1 cycles from capture to done; enable is a level hold, dropping it aborts or releases the result.
module point_jacobian #(
  parameter int LEN = 256
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [LEN-1:0] p,
  input  logic [LEN-1:0] p_prime,
  input  logic [LEN-1:0] r2_mod_p,
  input  logic           enable,
  input  logic [LEN-1:0] x,
  input  logic [LEN-1:0] y,
  input  logic [LEN-1:0] z,
  output logic [LEN-1:0] rx,
  output logic [LEN-1:0] ry,
  output logic [LEN-1:0] rz,
  output logic           done
);

  localparam int CW = $clog2(LEN + 1);

  typedef enum logic [2:0] {IDLE, LOAD, M1, M2, M3, M4, M5, DONE} state_t;

  state_t state, state_n;

  logic [LEN-1:0] pr, r2r, xr, yr, zr;
  logic           p0;
  logic [LEN-1:0] t1, t2, t3, rxn;
  logic [LEN+1:0] tacc;
  logic [LEN-1:0] a_sh, b_op;
  logic [CW-1:0]  cnt;

  logic           mul_last, a_bit, q, ge;
  logic [LEN+2:0] sum;
  logic [LEN+1:0] tsub;
  logic [LEN-1:0] mres, nxt_a, nxt_b;
  logic           unused_bits;

  assign mul_last = (cnt == CW'(LEN));
  assign a_bit    = a_sh[0];
  assign q        = (tacc[0] ^ (a_bit & b_op[0])) & p0;
  assign sum      = {1'b0, tacc} + (a_bit ? {3'b0, b_op} : '0) + (q ? {3'b0, pr} : '0);
  // tacc stays below 2p, so a single conditional subtract lands the result in [0,p)
  assign ge       = (tacc >= {2'b0, pr});
  assign tsub     = tacc - {2'b0, pr};
  assign mres     = ge ? tsub[LEN-1:0] : tacc[LEN-1:0];

  assign unused_bits = ^{p_prime[LEN-1:1], tsub[LEN+1:LEN], sum[0]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    nxt_a   = '0;
    nxt_b   = '0;
    case (state)
      IDLE: if (enable) state_n = LOAD;
      LOAD: state_n = enable ? M1 : IDLE;
      M1:   if (!enable) state_n = IDLE; else if (mul_last) state_n = M2;
      M2:   if (!enable) state_n = IDLE; else if (mul_last) state_n = M3;
      M3:   if (!enable) state_n = IDLE; else if (mul_last) state_n = M4;
      M4:   if (!enable) state_n = IDLE; else if (mul_last) state_n = M5;
      M5:   if (!enable) state_n = IDLE; else if (mul_last) state_n = DONE;
      DONE: if (!enable) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // operands for the multiply that follows the current state
    case (state)
      LOAD: begin nxt_a = zr;   nxt_b = r2r;  end
      M1:   begin nxt_a = mres; nxt_b = mres; end
      M2:   begin nxt_a = mres; nxt_b = t1;   end
      M3:   begin nxt_a = xr;   nxt_b = t2;   end
      M4:   begin nxt_a = yr;   nxt_b = t3;   end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx   <= '0;
      ry   <= '0;
      rz   <= '0;
      done <= 1'b0;
      cnt  <= '0;
      tacc <= '0;
    end else begin
      case (state)
        IDLE: if (enable) begin
          pr  <= p;
          p0  <= p_prime[0];
          r2r <= r2_mod_p;
          xr  <= x;
          yr  <= y;
          zr  <= z;
        end
        LOAD: begin
          a_sh <= nxt_a;
          b_op <= nxt_b;
          tacc <= '0;
          cnt  <= '0;
        end
        M1, M2, M3, M4, M5: begin
          if (!mul_last) begin
            tacc <= sum[LEN+2:1];
            a_sh <= a_sh >> 1;
            cnt  <= cnt + CW'(1);
          end else begin
            a_sh <= nxt_a;
            b_op <= nxt_b;
            tacc <= '0;
            cnt  <= '0;
            case (state)
              M1: t1  <= mres;
              M2: t2  <= mres;
              M3: t3  <= mres;
              M4: rxn <= mres;
              default: ;
            endcase
          end
        end
        DONE: if (!enable) done <= 1'b0;
        default: ;
      endcase
      if (state == M5 && state_n == DONE) begin
        rx   <= rxn;
        ry   <= mres;
        rz   <= zr;
        done <= 1'b1;
      end
    end
  end

endmodule
